// File: rtl/riscv_pkg.sv
// Shared core-wide constants and the fetch FIFO entry type.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int PC_STEP = 4;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Registered {pc, instr} FIFO between instruction memory and decode.
// Occupancy is tracked by count; pointers simply wrap.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  fetch_entry_t      push_entry,
  input  logic              pop,
  output logic [CNT_W-1:0]  count,
  output fetch_entry_t      head
);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; the head is forced to zero whenever empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign count = count_q;
  assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: PC generation, credit-limited request issue, in-order
// response capture and redirect flush with drop of in-flight responses.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] count;
  logic [XLEN-1:0]  redirect_aligned;
  logic             credit_ok, req_fire, rsp_push, pop;
  fetch_entry_t     head, push_entry;

  // A request may only issue if its response is guaranteed a FIFO slot.
  assign credit_ok        = ({1'b0, count} + {1'b0, outstanding_q}) < SUM_W'(DEPTH);
  assign imem_req_valid   = rst && !redirect_valid && credit_ok;
  assign imem_req_addr    = fetch_pc_q;
  assign req_fire         = imem_req_valid && imem_req_ready;
  assign instr_valid      = (count != '0) && !redirect_valid;
  assign pop              = instr_valid && instr_ready;
  assign instr            = head.instr;
  assign instr_pc         = head.pc;
  assign redirect_aligned = redirect_pc & ~XLEN'(3);
  assign push_entry       = '{pc: rsp_pc_q, instr: imem_rsp_data};

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    drop_d        = drop_q;
    rsp_push      = 1'b0;
    outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
    end
    if (redirect_valid) begin
      // Everything still in flight after this cycle belongs to the old path.
      fetch_pc_d = redirect_aligned;
      rsp_pc_d   = redirect_aligned;
      drop_d     = outstanding_d;
    end else if (imem_rsp_valid) begin
      if (drop_q != '0) begin
        drop_d = drop_q - CNT_W'(1);
      end else begin
        rsp_push = 1'b1;
        rsp_pc_d = rsp_pc_q + XLEN'(PC_STEP);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (rsp_push),
    .push_entry (push_entry),
    .pop        (pop),
    .count      (count),
    .head       (head)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: in-order memory model with set latency,
// expected PC stream queued per test and checked by an independent monitor.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } mreq_t;

  mreq_t       memq[$];
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          lat = 1;
  int          n_pops = 0;
  int          n_acc = 0;
  int          first_pop_cyc = -1;
  logic        nxt_rst = 1'b0, nxt_redir = 1'b0, nxt_ready = 1'b1, nxt_iready = 1'b1;
  logic        nxt_rnd = 1'b0;
  logic [31:0] nxt_redir_pc = '0;
  logic        chk_contig = 1'b0, have_prev = 1'b0;
  logic [31:0] prev_addr = '0;
  logic        obs_req_valid, obs_instr_valid;
  logic [31:0] obs_req_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: inputs applied at the falling edge, outputs observed 2ns later.
  task automatic step();
    int due;
    @(negedge clk);
    rst            = nxt_rst;
    redirect_valid = nxt_redir;
    redirect_pc    = nxt_redir_pc;
    imem_req_ready = nxt_rnd ? 1'($urandom_range(0, 1)) : nxt_ready;
    instr_ready    = nxt_iready;
    if (!nxt_rst) memq.delete();
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = ~memq[0].addr;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #2;
    obs_req_valid   = imem_req_valid;
    obs_req_addr    = imem_req_addr;
    obs_instr_valid = instr_valid;
    if (rst && imem_req_valid && imem_req_ready) begin
      due = cyc + lat;
      if (memq.size() > 0 && memq[$].due >= due) due = memq[$].due + 1;
      memq.push_back('{due: due, addr: imem_req_addr});
      n_acc++;
      if (chk_contig && have_prev) check("req_contig", imem_req_addr, prev_addr + 32'd4);
      prev_addr = imem_req_addr;
      have_prev = 1'b1;
    end
    if (imem_rsp_valid) begin
      assert (memq.size() > 0) else $error("response with nothing outstanding");
      void'(memq.pop_front());
    end
    cyc++;
  endtask

  // Monitor: every handshake toward decode must match the next expected PC.
  always @(negedge clk) begin
    #1;
    if (rst && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pop: got pc %h expected none", instr_pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("instr_pc", instr_pc, e);
        check("instr", instr, ~e);
      end
      if (n_pops == 0) first_pop_cyc = cyc;
      n_pops++;
    end
  end

  task automatic push_stream(input logic [31:0] base, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  task automatic do_reset();
    nxt_rst = 1'b0;
    nxt_redir = 1'b0;
    step();
    exp_q.delete();
    n_pops = 0;
    n_acc = 0;
    first_pop_cyc = -1;
  endtask

  int c0;

  initial begin
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);

    // Latency 1, everything ready: one request per cycle, valid 2 cycles later.
    lat = 1; nxt_ready = 1'b1; nxt_iready = 1'b1;
    push_stream(32'h0, 16);
    nxt_rst = 1'b1; c0 = cyc; step();
    check("t1_first_req_valid", 32'(obs_req_valid), 32'd1);
    check("t1_first_req_addr", obs_req_addr, 32'h0);
    step();
    check("t1_second_req_addr", obs_req_addr, 32'h4);
    for (int i = 0; i < 9; i++) step();
    check("t1_first_valid_lat", 32'(first_pop_cyc - c0), 32'd2);
    check("t1_pops", 32'(n_pops), 32'd9);

    // Decode stalled, latency 3: exactly DEPTH requests then stop.
    do_reset();
    lat = 3; nxt_iready = 1'b0;
    push_stream(32'h0, 16);
    nxt_rst = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("t2_accepts", 32'(n_acc), 32'd4);
    check("t2_req_stalled", 32'(obs_req_valid), 32'd0);
    check("t2_instr_valid", 32'(obs_instr_valid), 32'd1);
    nxt_iready = 1'b1;
    step();
    check("t2_req_still_off", 32'(obs_req_valid), 32'd0);
    step();
    check("t2_resume_valid", 32'(obs_req_valid), 32'd1);
    check("t2_resume_addr", obs_req_addr, 32'h10);
    step(); step();
    check("t2_pops", 32'(n_pops), 32'd4);
    step();
    check("t2_drained", 32'(obs_instr_valid), 32'd0);

    // Redirect with 3 outstanding while the first response arrives.
    do_reset();
    lat = 3; nxt_iready = 1'b1;
    nxt_rst = 1'b1; c0 = cyc;
    step(); step(); step();
    check("t3_accepts", 32'(n_acc), 32'd3);
    push_stream(32'h100, 16);
    nxt_redir = 1'b1; nxt_redir_pc = 32'h100;
    step();
    check("t3_redir_no_req", 32'(obs_req_valid), 32'd0);
    nxt_redir = 1'b0;
    step();
    check("t3_new_req_valid", 32'(obs_req_valid), 32'd1);
    check("t3_new_req_addr", obs_req_addr, 32'h100);
    for (int i = 0; i < 6; i++) step();
    check("t3_first_valid", 32'(first_pop_cyc - c0), 32'd8);
    check("t3_pops", 32'(n_pops), 32'd3);

    // Misaligned redirect mid-stream with a non-empty FIFO.
    push_stream(32'h200, 16);
    n_pops = 0; first_pop_cyc = -1;
    nxt_redir = 1'b1; nxt_redir_pc = 32'h202; c0 = cyc;
    step();
    check("t4_redir_masks_valid", 32'(obs_instr_valid), 32'd0);
    nxt_redir = 1'b0;
    step();
    check("t4_req_addr", obs_req_addr, 32'h200);
    for (int i = 0; i < 6; i++) step();
    check("t4_first_valid", 32'(first_pop_cyc - c0), 32'd5);

    // Random request backpressure: addresses stay contiguous.
    do_reset();
    lat = 1; nxt_iready = 1'b1; nxt_rnd = 1'b1;
    push_stream(32'h0, 64);
    chk_contig = 1'b1; have_prev = 1'b0;
    nxt_rst = 1'b1;
    for (int i = 0; i < 60; i++) step();
    check("t5_progress", 32'(n_pops >= 10), 32'd1);
    chk_contig = 1'b0; nxt_rnd = 1'b0;

    // Asynchronous reset with a full FIFO.
    do_reset();
    lat = 1; nxt_ready = 1'b1; nxt_iready = 1'b0;
    nxt_rst = 1'b1;
    for (int i = 0; i < 8; i++) step();
    check("t6_full_valid", 32'(obs_instr_valid), 32'd1);
    check("t6_full_no_req", 32'(obs_req_valid), 32'd0);
    rst = 1'b0;
    #1;
    check("t6_rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("t6_rst_req_addr", imem_req_addr, 32'h0);
    check("t6_rst_instr_valid", 32'(instr_valid), 32'd0);
    check("t6_rst_instr", instr, 32'h0);
    check("t6_rst_instr_pc", instr_pc, 32'h0);
    do_reset();
    nxt_rst = 1'b1;
    step();
    check("t6_after_req_valid", 32'(obs_req_valid), 32'd1);
    check("t6_after_req_addr", obs_req_addr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
